// File: rtl/irq_enc8to3_pkg.sv
// Shared types and constants for the 8-to-3 interrupt request encoder.
// Sized for exactly eight request lines.
package irq_enc8to3_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // One-hot mask selecting the pending bit that a granted id refers to.
    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_enc8to3_if.sv
// Request/grant bundle between the event sources, the encoder and the consumer.
// The slave side is the encoder; the master side drives requests and ack.
interface irq_enc8to3_if
    import irq_enc8to3_pkg::*;
();

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] mask;
    logic             ack;
    logic [ID_W-1:0]  id;
    logic             valid;
    logic [N_REQ-1:0] pend;

    modport master (
        output en, req, mask, ack,
        input  id, valid, pend
    );

    modport slave (
        input  en, req, mask, ack,
        output id, valid, pend
    );

endinterface

// File: rtl/irq_enc8to3_prio.sv
// Combinational priority encoder: the highest set input index wins, 0 when none set.
// Used by the interrupt encoder to pick among eligible pending requests.
module prio_enc8to3
    import irq_enc8to3_pkg::*;
(
    input  logic [N_REQ-1:0] in_i,
    output logic [ID_W-1:0]  out_o,
    output logic             vld_o
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        out_o = '0;
        // Ascending scan: later (higher) indices overwrite lower ones.
        for (int i = 0; i < N_REQ; i++) begin
            if (in_i[i]) out_o = ID_W'(i);
        end
    end

    assign vld_o = |in_i;

endmodule

// File: rtl/irq_enc8to3.sv
// Interrupt request encoder: latches request rising edges into pending flags and
// hands out the highest-priority unmasked one as an id that is held until acked.
module irq_enc8to3
    import irq_enc8to3_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    irq_enc8to3_if.slave       irq_io
);

    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pend_q, pend_d;
    state_e           state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] elig;
    logic [ID_W-1:0]  enc_id;
    logic             enc_vld;

    assign rise = irq_io.req & ~req_q;
    assign clr  = (state_q == ST_GRANT && irq_io.ack) ? onehot(id_q) : '0;
    assign elig = pend_q & irq_io.mask;

    // Clear is applied before set so a fresh edge in the ack cycle survives.
    assign pend_d = (pend_q & ~clr) | (irq_io.en ? rise : '0);

    prio_enc8to3 u_prio (
        .in_i  (elig),
        .out_o (enc_id),
        .vld_o (enc_vld)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (irq_io.en && enc_vld) begin
                    id_d    = enc_id;
                    valid_d = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // An outstanding grant ignores en, mask and new arrivals.
                if (irq_io.ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            pend_q  <= '0;
            state_q <= ST_IDLE;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            req_q   <= irq_io.req;
            pend_q  <= pend_d;
            state_q <= state_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign irq_io.id    = id_q;
    assign irq_io.valid = valid_q;
    assign irq_io.pend  = pend_q;

endmodule
